p2s_serializer_param: RTL and testbench

- Parametrised successor to the fixed 4-lane x 8-bit parallel-to-serial path.
- Captures one LANES x WIDTH parallel word through a valid/ready handshake and shifts it out one bit per lane per CLK.
- Owns its own bit counter, so no external sel is needed.
- Fills gaps with an idle symbol and supports MSB-first or LSB-first order per word.
- Sits between the lane-distribution stage and the serial line drivers.

---
 rtl/p2s_serializer_param_pkg.sv | 17 +
 rtl/p2s_serializer_param_if.sv | 37 +++
 rtl/p2s_lane_shift.sv | 47 ++++
 rtl/p2s_serializer_param.sv | 94 +++++++++
 tb/tb_p2s_serializer_param.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/p2s_serializer_param_pkg.sv
// Shared definitions for the parametrised parallel-to-serial path.
package p2s_serializer_param_pkg;

  // Defaults for the reference 4 x 8 configuration.
  localparam int unsigned P2S_DEF_LANES = 4;
  localparam int unsigned P2S_DEF_WIDTH = 8;

  // Default per-lane idle symbol.
  localparam logic [7:0] P2S_IDLE_SYM = 8'hBC;

  // Line state: idle symbol or payload on the lanes.
  typedef enum logic {
    P2S_IDLE = 1'b0,
    P2S_DATA = 1'b1
  } p2s_state_e;

endpackage : p2s_serializer_param_pkg

// File: rtl/p2s_serializer_param_if.sv
// Parallel load handshake and serial lane outputs of the serializer.
interface p2s_serializer_param_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8
);

  logic                   valid_in;
  logic                   msb_first;
  logic [LANES*WIDTH-1:0] data_in;
  logic                   ready_out;
  logic [LANES-1:0]       data_out;
  logic                   valid_out;
  logic                   frame_start;

  // Producer / line-driver side.
  modport master (
    output valid_in,
    output msb_first,
    output data_in,
    input  ready_out,
    input  data_out,
    input  valid_out,
    input  frame_start
  );

  // Serializer side.
  modport slave (
    input  valid_in,
    input  msb_first,
    input  data_in,
    output ready_out,
    output data_out,
    output valid_out,
    output frame_start
  );

endinterface : p2s_serializer_param_if

// File: rtl/p2s_lane_shift.sv
// One serial lane: loadable shift register with a per-word bit-order latch.
module p2s_lane_shift #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             load_msb_i,
  output logic             head_o
);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             msb_q, msb_d;

  // Lane register and order latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      msb_q   <= 1'b1;
    end else begin
      shreg_q <= shreg_d;
      msb_q   <= msb_d;
    end
  end

  // Load a new word at the slot, otherwise shift toward the head in the latched order.
  always_comb begin
    shreg_d = shreg_q;
    msb_d   = msb_q;
    if (en_i) begin
      if (load_i) begin
        shreg_d = load_val_i;
        msb_d   = load_msb_i;
      end else if (msb_q) begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      end
    end
  end

  // Head bit is the one currently on the line.
  assign head_o = msb_q ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule : p2s_lane_shift

// File: rtl/p2s_serializer_param.sv
// LANES x WIDTH parallel-to-serial converter with idle fill and per-word bit order.
module p2s_serializer_param
  import p2s_serializer_param_pkg::*;
#(
  parameter int unsigned      LANES     = P2S_DEF_LANES,
  parameter int unsigned      WIDTH     = P2S_DEF_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(P2S_IDLE_SYM)
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  ENB,
  p2s_serializer_param_if.slave bus
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  p2s_state_e       state_q, state_d;
  logic             load_slot;
  logic [LANES-1:0] head;

  // A load happens on every enabled edge at the last bit position.
  assign load_slot = ENB && (cnt_q == CNT_LAST);

  // Bit counter register; reset parks it on the load slot.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt_q <= CNT_LAST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Bit counter next value: wrap to 0 at the slot, otherwise step when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (ENB) begin
      if (load_slot) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= P2S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: decided only at the load slot by whether a word is offered.
  always_comb begin
    state_d = state_q;
    if (load_slot) begin
      state_d = bus.valid_in ? P2S_DATA : P2S_IDLE;
    end
  end

  // FSM outputs decoded from registered state and counter.
  always_comb begin
    bus.valid_out   = (state_q == P2S_DATA);
    bus.frame_start = (cnt_q == '0);
    bus.ready_out   = reset && load_slot;
  end

  // One shift register per lane; idle words always go out MSB-first.
  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    logic [WIDTH-1:0] load_val;
    logic             load_msb;

    assign load_val = bus.valid_in ? bus.data_in[k*WIDTH +: WIDTH] : IDLE_WORD;
    assign load_msb = bus.valid_in ? bus.msb_first : 1'b1;

    p2s_lane_shift #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk        (CLK),
      .rst_n      (reset),
      .en_i       (ENB),
      .load_i     (load_slot),
      .load_val_i (load_val),
      .load_msb_i (load_msb),
      .head_o     (head[k])
    );
  end

  assign bus.data_out = head;

endmodule : p2s_serializer_param

// File: tb/tb_p2s_serializer_param.sv
// Scoreboard bench for p2s_serializer_param in the 4 x 8 configuration.
module tb_p2s_serializer_param;

  localparam int unsigned LANES = 4;
  localparam int unsigned WIDTH = 8;

  logic CLK;
  logic reset;
  logic ENB;

  p2s_serializer_param_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

  p2s_serializer_param #(
    .LANES     (LANES),
    .WIDTH     (WIDTH),
    .IDLE_WORD (8'hBC)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .ENB   (ENB),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected output per enabled edge: {frame_start, valid_out, data_out[3:0]}.
  logic [5:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       mon_on   = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit i of a word on all lanes; idle words are 8'hBC sent MSB-first.
  function automatic logic [3:0] exp_bits(input logic v, input logic m,
                                          input logic [31:0] d, input int i);
    logic [7:0] w;
    logic [3:0] r;
    for (int k = 0; k < 4; k++) begin
      w    = v ? d[k*8 +: 8] : 8'hBC;
      r[k] = (m || !v) ? w[7-i] : w[i];
    end
    return r;
  endfunction

  // Offer one word at the next load slot and queue its eight expected bit times.
  task automatic send(input logic v, input logic m, input logic [31:0] d);
    int waited = 0;
    while (!bus.ready_out && waited < 40) begin
      @(negedge CLK);
      waited++;
    end
    if (!bus.ready_out) begin
      chk("ready_timeout", 32'(bus.ready_out), 32'd1);
      return;
    end
    bus.valid_in  = v;
    bus.msb_first = m;
    bus.data_in   = d;
    for (int i = 0; i < 8; i++)
      exp_q.push_back({(i == 0), v, exp_bits(v, m, d, i)});
    @(posedge CLK);
    #1;
    // Disturb inputs mid-word; the word in flight must be unaffected.
    bus.data_in   = ~d;
    bus.msb_first = ~m;
  endtask

  // Monitor: every enabled edge out of reset presents exactly one bit time.
  initial begin
    logic       en_s, rs_s;
    logic [5:0] e;
    forever begin
      @(posedge CLK);
      en_s = ENB;
      rs_s = reset;
      #1;
      if (mon_on && en_s && rs_s) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_underflow: output 0x%0h with no expected entry at %0t",
                   {bus.frame_start, bus.valid_out, bus.data_out}, $time);
        end else begin
          e = exp_q.pop_front();
          chk("serial_out", 32'({bus.frame_start, bus.valid_out, bus.data_out}), 32'(e));
        end
      end
    end
  end

  // Stimulus.
  initial begin
    logic [3:0] frozen;
    reset         = 1'b0;
    ENB           = 1'b1;
    bus.valid_in  = 1'b0;
    bus.msb_first = 1'b1;
    bus.data_in   = '0;

    // Reset state with ENB high.
    repeat (3) @(negedge CLK);
    chk("rst_data_out",    32'(bus.data_out),    32'd0);
    chk("rst_valid_out",   32'(bus.valid_out),   32'd0);
    chk("rst_ready_out",   32'(bus.ready_out),   32'd0);
    chk("rst_frame_start", 32'(bus.frame_start), 32'd0);
    reset = 1'b1;
    #1;
    chk("release_ready", 32'(bus.ready_out), 32'd1);

    // Single word MSB-first, then LSB-first.
    send(1'b1, 1'b1, 32'hFF_AA_55_00);
    send(1'b1, 1'b0, 32'h0000_0001);

    // Idle fill (data ignored; order forced to MSB-first).
    send(1'b0, 1'b0, 32'hDEAD_BEEF);
    send(1'b0, 1'b1, 32'h0000_0000);

    // Back-to-back payload.
    send(1'b1, 1'b1, 32'h1234_5678);
    send(1'b1, 1'b1, 32'h9ABC_DEF0);

    // ENB pause while bit 3 is on the line.
    send(1'b1, 1'b1, 32'hA5C3_0FF0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    ENB    = 1'b0;
    frozen = exp_bits(1'b1, 1'b1, 32'hA5C3_0FF0, 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("pause_data_out",  32'(bus.data_out),  32'(frozen));
      chk("pause_ready_out", 32'(bus.ready_out), 32'd0);
      chk("pause_valid_out", 32'(bus.valid_out), 32'd1);
    end
    ENB = 1'b1;

    // Reset asserted while bit 5 is on the line.
    send(1'b1, 1'b0, 32'h0F1E_2D3C);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_data_out",    32'(bus.data_out),    32'd0);
    chk("midrst_valid_out",   32'(bus.valid_out),   32'd0);
    chk("midrst_frame_start", 32'(bus.frame_start), 32'd0);
    chk("midrst_ready_out",   32'(bus.ready_out),   32'd0);
    exp_q.delete();
    @(negedge CLK);
    reset = 1'b1;
    #1;
    chk("rerelease_ready", 32'(bus.ready_out), 32'd1);

    send(1'b1, 1'b1, 32'h1357_9BDF);
    send(1'b0, 1'b0, 32'h0000_0000);
    bus.valid_in = 1'b0;
    repeat (7) @(posedge CLK);
    #2;
    mon_on = 1'b0;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

endmodule : tb_p2s_serializer_param
